regfile_write_scheduler: RTL and testbench

Shares the register bank's single write port among several writeback requesters (ALU, load unit, mult/div unit) and tracks pending destination registers for hazard checks. Sits between the execute/memory/writeback stages and the register bank: drives the bank's `reg_write`, `write_register` and `write_data` inputs, and answers busy queries from the issue stage.

---
 rtl/regfile_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/regfile_write_scheduler.sv | 108 ++++++++++
 tb/tb_regfile_write_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register-bank write scheduler: bank geometry,
// the hard-wired zero register and the writeback requester indices.
package regfile_pkg;
    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int REG_ZERO   = 0;
    localparam int REQ_ALU    = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_MULDIV = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating priority pointer,
// pointer moves past the winner whenever a transfer happens.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);
    import regfile_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    int               grant_idx;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = 0;
        found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && valid[(int'(ptr) + k) % NUM_REQ]) begin
                found                                  = 1'b1;
                grant_idx                              = (int'(ptr) + k) % NUM_REQ;
                grant[(int'(ptr) + k) % NUM_REQ]       = 1'b1;
            end
        end
    end

    // The winner drops to lowest priority for the next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= PTR_W'(REQ_ALU);
        end else if (advance) begin
            ptr <= PTR_W'((grant_idx + 1) % NUM_REQ);
        end
    end
endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register bank write port among the writeback units and keeps the
// pending-destination scoreboard used by the issue stage for hazard checks.
module regfile_write_scheduler #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = regfile_pkg::DATA_W,
    parameter int ADDR_W  = regfile_pkg::ADDR_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      reg_write,
    output logic [ADDR_W-1:0]         write_register,
    output logic [DATA_W-1:0]         write_data,
    input  logic                      reserve_valid,
    input  logic [ADDR_W-1:0]         reserve_addr,
    input  logic [ADDR_W-1:0]         check_addr_1,
    input  logic [ADDR_W-1:0]         check_addr_2,
    output logic                      check_busy_1,
    output logic                      check_busy_2,
    output logic [(2**ADDR_W)-1:0]    busy_vector
);
    import regfile_pkg::*;

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REQ-1:0]  grant;
    logic                transfer;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                wr_vld_p1;
    logic [ADDR_W-1:0]   wr_addr_p1;
    logic [DATA_W-1:0]   wr_data_p1;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_nxt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
        .clock   (clock),
        .reset   (reset),
        .valid   (req_valid),
        .advance (transfer),
        .grant   (grant)
    );

    assign req_ready = reset ? '0 : grant;
    assign transfer  = |req_ready;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
                sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // ---- p1: registered bank write port ----
    // A write to the zero register still completes its handshake but never
    // raises the bank enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else if (transfer) begin
            wr_vld_p1  <= (sel_addr != ADDR_W'(REG_ZERO));
            wr_addr_p1 <= sel_addr;
            wr_data_p1 <= sel_data;
        end else begin
            wr_vld_p1  <= 1'b0;
        end
    end

    assign reg_write      = wr_vld_p1;
    assign write_register = wr_addr_p1;
    assign write_data     = wr_data_p1;

    // Reservation is applied after the commit clear so a same-register
    // re-reservation survives the retiring write.
    always_comb begin
        busy_nxt = busy_q;
        if (wr_vld_p1) begin
            busy_nxt[wr_addr_p1] = 1'b0;
        end
        if (reserve_valid) begin
            busy_nxt[reserve_addr] = 1'b1;
        end
        busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign busy_vector  = busy_q;
    assign check_busy_1 = busy_q[check_addr_1];
    assign check_busy_2 = busy_q[check_addr_2];
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: scenario tasks with an expected-write queue.
module tb_regfile_write_scheduler;
    import regfile_pkg::*;

    localparam int NR = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct {
        logic          vld;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic              clock;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic              reg_write;
    logic [AW-1:0]     write_register;
    logic [DW-1:0]     write_data;
    logic              reserve_valid;
    logic [AW-1:0]     reserve_addr;
    logic [AW-1:0]     check_addr_1;
    logic [AW-1:0]     check_addr_2;
    logic              check_busy_1;
    logic              check_busy_2;
    logic [(2**AW)-1:0] busy_vector;

    int  checks = 0;
    int  passed = 0;
    wr_t sb[$];

    regfile_write_scheduler #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .ADDR_W  (AW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .reg_write      (reg_write),
        .write_register (write_register),
        .write_data     (write_data),
        .reserve_valid  (reserve_valid),
        .reserve_addr   (reserve_addr),
        .check_addr_1   (check_addr_1),
        .check_addr_2   (check_addr_2),
        .check_busy_1   (check_busy_1),
        .check_busy_2   (check_busy_2),
        .busy_vector    (busy_vector)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        req_valid     = 3'b111;
        req_addr      = {5'd10, 5'd9, 5'd8};
        req_data      = {32'hC, 32'hB, 32'hA};
        reserve_valid = 1'b0;
        reserve_addr  = '0;
        check_addr_1  = '0;
        check_addr_2  = '0;
        tick();
        tick();
        #1;
        checks++;
        if (req_ready !== 3'b000) $display("FAIL reset_ready: got %b want 000", req_ready);
        else passed++;
        checks++;
        if (reg_write !== 1'b0) $display("FAIL reset_reg_write: got %b want 0", reg_write);
        else passed++;
        checks++;
        if (write_register !== 5'd0 || write_data !== 32'd0)
            $display("FAIL reset_addr_data: got %0d/%0h want 0/0", write_register, write_data);
        else passed++;
        checks++;
        if (busy_vector !== 32'd0) $display("FAIL reset_busy: got %h want 0", busy_vector);
        else passed++;
        req_valid = 3'b000;
        reset     = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] addr_tab[NR];
        logic [DW-1:0] data_tab[NR];
        logic [NR-1:0] exp_ready;
        wr_t           e;
        addr_tab  = '{5'd8, 5'd9, 5'd10};
        data_tab  = '{32'hA, 32'hB, 32'hC};
        req_addr  = {5'd10, 5'd9, 5'd8};
        req_data  = {32'hC, 32'hB, 32'hA};
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_ready = '0;
            exp_ready[c % NR] = 1'b1;
            checks++;
            if (req_ready !== exp_ready)
                $display("FAIL rr_grant c%0d: got %b want %b", c, req_ready, exp_ready);
            else passed++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (reg_write !== e.vld || write_register !== e.addr || write_data !== e.data)
                    $display("FAIL rr_write c%0d: got %b/%0d/%0h want %b/%0d/%0h", c,
                             reg_write, write_register, write_data, e.vld, e.addr, e.data);
                else passed++;
            end
            sb.push_back('{1'b1, addr_tab[c % NR], data_tab[c % NR]});
            tick();
        end
        req_valid = 3'b000;
        #1;
        checks++;
        if (req_ready !== 3'b000) $display("FAIL rr_idle_ready: got %b want 000", req_ready);
        else passed++;
        e = sb.pop_front();
        checks++;
        if (reg_write !== e.vld || write_register !== e.addr || write_data !== e.data)
            $display("FAIL rr_write_last: got %b/%0d/%0h want %b/%0d/%0h",
                     reg_write, write_register, write_data, e.vld, e.addr, e.data);
        else passed++;
        tick();
        checks++;
        if (reg_write !== 1'b0) $display("FAIL rr_drain: got %b want 0", reg_write);
        else passed++;
    endtask

    task automatic test_zero_write();
        wr_t e;
        req_addr[REQ_LOAD*AW +: AW] = 5'd0;
        req_data[REQ_LOAD*DW +: DW] = 32'hFFFF_FFFF;
        req_valid = 3'b010;
        #1;
        checks++;
        if (req_ready !== 3'b010) $display("FAIL zero_grant: got %b want 010", req_ready);
        else passed++;
        sb.push_back('{1'b0, 5'd0, 32'hFFFF_FFFF});
        tick();
        req_valid = 3'b000;
        #1;
        e = sb.pop_front();
        checks++;
        if (reg_write !== e.vld || write_register !== e.addr || write_data !== e.data)
            $display("FAIL zero_write: got %b/%0d/%0h want %b/%0d/%0h",
                     reg_write, write_register, write_data, e.vld, e.addr, e.data);
        else passed++;
        tick();
        checks++;
        if (busy_vector !== 32'd0) $display("FAIL zero_busy: got %h want 0", busy_vector);
        else passed++;
        req_addr[REQ_LOAD*AW +: AW] = 5'd9;
        req_data[REQ_LOAD*DW +: DW] = 32'hB;
    endtask

    task automatic test_reserve_clear();
        wr_t e;
        check_addr_1  = 5'd12;
        reserve_valid = 1'b1;
        reserve_addr  = 5'd12;
        #1;
        checks++;
        if (check_busy_1 !== 1'b0) $display("FAIL rsv_before: got %b want 0", check_busy_1);
        else passed++;
        tick();
        reserve_valid = 1'b0;
        #1;
        checks++;
        if (check_busy_1 !== 1'b1) $display("FAIL rsv_set: got %b want 1", check_busy_1);
        else passed++;
        tick();
        req_addr[REQ_MULDIV*AW +: AW] = 5'd12;
        req_data[REQ_MULDIV*DW +: DW] = 32'h1234;
        req_valid = 3'b100;
        #1;
        checks++;
        if (req_ready !== 3'b100 || check_busy_1 !== 1'b1)
            $display("FAIL rsv_grant: got %b/%b want 100/1", req_ready, check_busy_1);
        else passed++;
        sb.push_back('{1'b1, 5'd12, 32'h1234});
        tick();
        req_valid = 3'b000;
        #1;
        e = sb.pop_front();
        checks++;
        if (reg_write !== e.vld || write_register !== e.addr || write_data !== e.data)
            $display("FAIL rsv_write: got %b/%0d/%0h want %b/%0d/%0h",
                     reg_write, write_register, write_data, e.vld, e.addr, e.data);
        else passed++;
        checks++;
        if (check_busy_1 !== 1'b1) $display("FAIL rsv_hold: got %b want 1", check_busy_1);
        else passed++;
        tick();
        checks++;
        if (check_busy_1 !== 1'b0 || busy_vector !== 32'd0)
            $display("FAIL rsv_clear: got %b/%h want 0/0", check_busy_1, busy_vector);
        else passed++;
        req_addr[REQ_MULDIV*AW +: AW] = 5'd10;
        req_data[REQ_MULDIV*DW +: DW] = 32'hC;
    endtask

    task automatic test_set_wins();
        reserve_valid = 1'b1;
        reserve_addr  = 5'd5;
        tick();
        reserve_valid = 1'b0;
        req_addr[REQ_ALU*AW +: AW] = 5'd5;
        req_data[REQ_ALU*DW +: DW] = 32'h55;
        req_valid = 3'b001;
        #1;
        checks++;
        if (req_ready !== 3'b001 || busy_vector[5] !== 1'b1)
            $display("FAIL sw_grant: got %b/%b want 001/1", req_ready, busy_vector[5]);
        else passed++;
        tick();
        req_valid     = 3'b000;
        reserve_valid = 1'b1;
        reserve_addr  = 5'd5;
        #1;
        checks++;
        if (reg_write !== 1'b1 || write_register !== 5'd5 || write_data !== 32'h55)
            $display("FAIL sw_commit: got %b/%0d/%0h want 1/5/55", reg_write, write_register, write_data);
        else passed++;
        tick();
        reserve_valid = 1'b0;
        #1;
        checks++;
        if (busy_vector !== 32'h0000_0020)
            $display("FAIL sw_busy: got %h want 00000020", busy_vector);
        else passed++;
        req_addr[REQ_ALU*AW +: AW] = 5'd8;
        req_data[REQ_ALU*DW +: DW] = 32'hA;
    endtask

    task automatic test_reset_mid();
        reset     = 1'b1;
        req_valid = 3'b111;
        #1;
        checks++;
        if (req_ready !== 3'b000) $display("FAIL rm_ready: got %b want 000", req_ready);
        else passed++;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (reg_write !== 1'b0 || write_register !== 5'd0 || write_data !== 32'd0)
            $display("FAIL rm_outputs: got %b/%0d/%0h want 0/0/0", reg_write, write_register, write_data);
        else passed++;
        checks++;
        if (busy_vector !== 32'd0) $display("FAIL rm_busy: got %h want 0", busy_vector);
        else passed++;
        checks++;
        if (req_ready !== 3'b001) $display("FAIL rm_ptr: got %b want 001", req_ready);
        else passed++;
        sb.push_back('{1'b1, 5'd8, 32'hA});
        tick();
        req_valid = 3'b000;
        #1;
        begin
            wr_t e;
            e = sb.pop_front();
            checks++;
            if (reg_write !== e.vld || write_register !== e.addr || write_data !== e.data)
                $display("FAIL rm_write: got %b/%0d/%0h want %b/%0d/%0h",
                         reg_write, write_register, write_data, e.vld, e.addr, e.data);
            else passed++;
        end
        tick();
    endtask

    task automatic test_reserve_zero();
        reserve_valid = 1'b1;
        reserve_addr  = 5'd0;
        check_addr_2  = 5'd0;
        tick();
        reserve_valid = 1'b0;
        #1;
        checks++;
        if (busy_vector[0] !== 1'b0 || check_busy_2 !== 1'b0)
            $display("FAIL zero_reserve: got %b/%b want 0/0", busy_vector[0], check_busy_2);
        else passed++;
        checks++;
        if (busy_vector !== 32'd0) $display("FAIL zero_reserve_vec: got %h want 0", busy_vector);
        else passed++;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        reserve_valid = 1'b0;
        reserve_addr = '0;
        check_addr_1 = '0;
        check_addr_2 = '0;
        #1;
        test_reset();
        test_round_robin();
        test_zero_write();
        test_reserve_clear();
        test_set_wins();
        test_reset_mid();
        test_reserve_zero();
        checks++;
        if (sb.size() != 0) $display("FAIL sb_leftover: got %0d want 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
